// File: rtl/dmem_port_arbiter.sv
// Purpose: shares one data-memory port between the core (port 0) and the debug/loader (port 1); macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break, else fixed priority.
// Latency: grant and memory strobe are combinational in IDLE; read data returns with rvalid MEM_LAT+1 cycles after the handshake.
// Backpressure: loser and any port during an outstanding read see ready=0; writes can be accepted every cycle.
module dmem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_lat_cnt;
  logic [2:0]        w_lat_cnt_nxt;
  logic              r_owner;
  logic              w_owner_nxt;
  logic              w_rd_done;
  logic              w_grant_any;
  logic              w_win;
  logic              w_sel_we;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;

  // A grant is only possible in IDLE; reset_n gating keeps every output at 0 while reset is held.
  assign w_grant_any = reset_n && (r_state == S_IDLE) && (req0_valid || req1_valid);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Round-robin winner: on a tie the port not granted last time wins.
  always_comb begin
    if (req0_valid && req1_valid) w_win = ~r_last_grant;
    else                          w_win = req1_valid;
  end

  // Remember the port of every handshake, reads and writes alike.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_last_grant <= 1'b1;
    else if (w_grant_any) r_last_grant <= w_win;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is idle.
  assign w_win = ~req0_valid;
`endif

  assign w_sel_we    = w_win ? req1_we : req0_we;
  assign req0_ready  = w_grant_any && !w_win;
  assign req1_ready  = w_grant_any &&  w_win;
  assign mem_en      = w_grant_any;
  assign mem_we      = w_grant_any && w_sel_we;
  assign mem_addr    = w_grant_any ? (w_win ? req1_addr  : req0_addr)  : '0;
  assign mem_wdata   = w_grant_any ? (w_win ? req1_wdata : req0_wdata) : '0;
  assign busy        = (r_state == S_WAIT);
  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

  // Next-state: a read grant parks the FSM in WAIT until the latency counter reaches 1.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_owner_nxt   = r_owner;
    w_rd_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any && !w_sel_we) begin
          w_state_nxt   = S_WAIT;
          w_lat_cnt_nxt = 3'(MEM_LAT);
          w_owner_nxt   = w_win;
        end
      end
      S_WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt = S_IDLE;
          w_rd_done   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, latency counter and read owner registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 3'd0;
      r_owner   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_owner   <= w_owner_nxt;
    end
  end

  // Capture read data for the owner only; the other port's data and strobe are left alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd_done && !r_owner;
      r_rvalid1 <= w_rd_done &&  r_owner;
      if (w_rd_done && !r_owner) r_rdata0 <= mem_rdata;
      if (w_rd_done &&  r_owner) r_rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// Latency: MEM_LAT=2 memory model built from a read-data pipeline.
// Backpressure: requesters hold their request until they see ready at a handshake.
module tb_dmem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b, want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Memory environment: word array, writes at the clock edge, reads through a LAT-deep pipeline.
  logic [31:0] tb_mem [64];
  logic [31:0] rd_pipe [LAT];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'(i) * 32'h01010101;
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
    if (mem_en && !mem_we) rd_pipe[0] <= tb_mem[mem_addr[7:2]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: counts of remaining wait cycles, a scheduled rvalid, and a shadow memory.
  logic [31:0] sh_mem [64];
  logic        sh_init = 1'b0;
  int          m_wait  = 0;
  int          m_rv    = -1;
  int          m_owner = 0;
  int          m_last  = 1;
  logic [31:0] m_pend  = 32'h0;
  logic [31:0] m_rd [2];

  always @(negedge clk) begin : model_p
    int   w;
    int   nrv;
    bit   idle;
    bit   gnt;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    if (!sh_init) begin
      for (int i = 0; i < 64; i++) sh_mem[i] = 32'(i) * 32'h01010101;
      sh_init = 1'b1;
    end
    if (!reset_n) begin
      m_wait = 0; m_rv = -1; m_owner = 0; m_last = 1;
      m_rd[0] = 32'h0; m_rd[1] = 32'h0;
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_wdata", mem_wdata, 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_rvalid0", req0_rvalid, 1'b0);
      chk1("rst_rvalid1", req1_rvalid, 1'b0);
      chk32("rst_rdata0", req0_rdata, 32'h0);
      chk32("rst_rdata1", req1_rdata, 32'h0);
    end else begin
      idle = (m_wait == 0);
      if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = 1 - m_last;
`else
        w = 0;
`endif
      end else begin
        w = req0_valid ? 0 : 1;
      end
      gnt     = idle && (req0_valid || req1_valid);
      s_we    = (w == 1) ? req1_we    : req0_we;
      s_addr  = (w == 1) ? req1_addr  : req0_addr;
      s_wdata = (w == 1) ? req1_wdata : req0_wdata;
      chk1("busy", busy, !idle);
      chk1("ready0", req0_ready, gnt && (w == 0));
      chk1("ready1", req1_ready, gnt && (w == 1));
      chk1("mem_en", mem_en, gnt);
      if (gnt) begin
        chk1("mem_we", mem_we, s_we);
        chk32("mem_addr", mem_addr, s_addr);
        if (s_we) chk32("mem_wdata", mem_wdata, s_wdata);
      end
      chk1("rvalid0", req0_rvalid, m_rv == 0);
      chk1("rvalid1", req1_rvalid, m_rv == 1);
      chk32("rdata0", req0_rdata, m_rd[0]);
      chk32("rdata1", req1_rdata, m_rd[1]);
      nrv = -1;
      if (!idle) begin
        m_wait--;
        if (m_wait == 0) begin
          m_rd[m_owner] = m_pend;
          nrv = m_owner;
        end
      end else if (gnt) begin
        m_last = w;
        if (s_we) sh_mem[s_addr[7:2]] = s_wdata;
        else begin
          m_wait  = LAT;
          m_owner = w;
          m_pend  = sh_mem[s_addr[7:2]];
        end
      end
      m_rv = nrv;
    end
  end

  // Requester queues and a log of every handshake.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  rq_t  q0[$];
  rq_t  q1[$];
  int   g_port[$];
  int   g_cyc[$];
  logic g_en[$];
  logic g_we[$];
  bit   gaps = 1'b0;

  task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    rq_t r;
    r.we = we; r.addr = a; r.wdata = d;
    if (p == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic clear_log();
    g_port.delete(); g_cyc.delete(); g_en.delete(); g_we.delete();
  endtask

  // Present queued requests, hold each until its handshake, stop after budget cycles.
  task automatic run_queues(input int budget);
    int c = 0;
    bit hs0, hs1;
    while ((q0.size() != 0 || q1.size() != 0) && c < budget) begin
      if (!req0_valid && q0.size() != 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
        req0_valid = 1'b1; req0_we = q0[0].we; req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
      end
      if (!req1_valid && q1.size() != 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
        req1_valid = 1'b1; req1_we = q1[0].we; req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
      end
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (hs0 || hs1) begin
        g_port.push_back(hs1 ? 1 : 0);
        g_cyc.push_back(cyc);
        g_en.push_back(mem_en);
        g_we.push_back(mem_we);
      end
      @(posedge clk); #1;
      if (hs0) begin req0_valid = 1'b0; void'(q0.pop_front()); end
      if (hs1) begin req1_valid = 1'b0; void'(q1.pop_front()); end
      c++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain: %0d/%0d requests left after %0d cycles", q0.size(), q1.size(), budget);
      q0.delete(); q1.delete();
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g [4];
    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    idle_cycles(3);

    // Requests during reset must not be granted.
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'h44; req1_addr = 32'h48;
    #1;
    chk1("lit_rst_ready0", req0_ready, 1'b0);
    chk1("lit_rst_ready1", req1_ready, 1'b0);
    chk1("lit_rst_mem_en", mem_en, 1'b0);
    chk32("lit_rst_mem_addr", mem_addr, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(1);
    reset_n = 1'b1;
    idle_cycles(2);

    // Tie: both ports queue two reads each.
    clear_log();
    push(0, 1'b0, 32'h40, 32'h0); push(0, 1'b0, 32'h44, 32'h0);
    push(1, 1'b0, 32'h80, 32'h0); push(1, 1'b0, 32'h84, 32'h0);
    run_queues(100);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 1, 1};
`endif
    chk32("tie_count", 32'(g_port.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < g_port.size()) chk32("tie_grant", 32'(g_port[i]), 32'(exp_g[i]));
    if (g_cyc.size() >= 2) chk32("tie_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'(LAT + 1));
    idle_cycles(LAT + 2);

    // Single read of 0xDEADBEEF from 0x10 on port 0.
    push(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_queues(20);
    idle_cycles(1);
    clear_log();
    push(0, 1'b0, 32'h10, 32'h0);
    run_queues(20);
    if (g_en.size() == 1) begin
      chk1("sr_mem_en", g_en[0], 1'b1);
      chk1("sr_mem_we", g_we[0], 1'b0);
    end
    @(negedge clk); chk1("sr_busy_n1", busy, 1'b1); chk1("sr_rv_n1", req0_rvalid, 1'b0);
    @(negedge clk); chk1("sr_busy_n2", busy, 1'b1); chk1("sr_rv_n2", req0_rvalid, 1'b0);
    @(negedge clk); chk1("sr_busy_n3", busy, 1'b0); chk1("sr_rv_n3", req0_rvalid, 1'b1);
    chk32("sr_rdata", req0_rdata, 32'hDEADBEEF);
    @(negedge clk); chk1("sr_rv_n4", req0_rvalid, 1'b0);
    chk32("sr_rdata_hold", req0_rdata, 32'hDEADBEEF);
    idle_cycles(1);

    // Write then read on port 1.
    clear_log();
    push(1, 1'b1, 32'h20, 32'h00000007);
    push(1, 1'b0, 32'h20, 32'h0);
    run_queues(20);
    if (g_cyc.size() == 2) begin
      chk1("wr_mem_we", g_we[0], 1'b1);
      chk32("wr_rd_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd1);
    end
    repeat (LAT) @(negedge clk);
    @(negedge clk);
    chk1("wr_rd_rvalid1", req1_rvalid, 1'b1);
    chk32("wr_rd_rdata1", req1_rdata, 32'h00000007);
    chk1("wr_rd_rvalid0", req0_rvalid, 1'b0);
    chk32("wr_rd_rdata0_kept", req0_rdata, 32'hDEADBEEF);
    idle_cycles(1);

    // Back-to-back: four writes in four cycles, then a grant in the rvalid cycle.
    clear_log();
    for (int i = 0; i < 4; i++) push(0, 1'b1, 32'h30 + 32'(4 * i), 32'hA0 + 32'(i));
    run_queues(20);
    if (g_cyc.size() == 4) chk32("b2b_writes", 32'(g_cyc[3] - g_cyc[0]), 32'd3);
    clear_log();
    push(0, 1'b0, 32'h30, 32'h0);
    push(1, 1'b0, 32'h34, 32'h0);
    run_queues(20);
    if (g_cyc.size() == 2) chk32("b2b_read_gap", 32'(g_cyc[1] - g_cyc[0]), 32'(LAT + 1));
    idle_cycles(LAT + 2);

    // Randomized traffic with idle gaps.
    gaps = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push(0, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 63)), $urandom);
      push(1, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 63)), $urandom);
    end
    run_queues(4000);
    gaps = 1'b0;
    idle_cycles(LAT + 2);

    // Reset during WAIT discards the pending read.
    push(0, 1'b0, 32'h30, 32'h0);
    run_queues(20);
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h38;
    #2;
    reset_n = 1'b0;
    #1;
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_ready1", req1_ready, 1'b0);
    chk1("mr_mem_en", mem_en, 1'b0);
    chk32("mr_rdata0", req0_rdata, 32'h0);
    idle_cycles(2);
    req1_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk1("mr_no_rvalid0", req0_rvalid, 1'b0);
      chk1("mr_no_rvalid1", req1_rvalid, 1'b0);
    end
    idle_cycles(1);

    // Short random run after reset recovery.
    gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(0, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 63)), $urandom);
      push(1, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 63)), $urandom);
    end
    run_queues(1500);
    idle_cycles(LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
